// File: rtl/soc1_led_sequencer.sv
// soc1_led_sequencer: autonomous LED pattern sequencer for the soc1 LEDR PIO.
// The CPU loads a pattern table, step period and last step index through the Avalon-MM
// slave port, then sets RUN. The block writes each pattern to the PIO data register through
// its Avalon-MM master port and holds it for PERIOD cycles before advancing.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   s_address/s_chipselect/
//   s_write_n/s_writedata       slave register writes
//   s_readdata                  slave register read data (combinational from s_address)
//   m_address/m_write_n/
//   m_writedata/m_waitrequest   master write port into the PIO (always word 0)
//   irq                         level interrupt, DONE & IRQ_EN
module soc1_led_sequencer #(
  parameter int unsigned         WIDTH          = 10,
  parameter int unsigned         DEPTH          = 8,
  parameter int unsigned         PERIOD_W       = 24,
  parameter logic [PERIOD_W-1:0] DEFAULT_PERIOD = 24'd500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [2:0]  m_address,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        irq
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWrite, StHold} state_e;

  state_e                state_q, state_d;
  logic                  run_q, run_d;
  logic                  loop_q, loop_d;
  logic                  irq_en_q, irq_en_d;
  logic                  done_q, done_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]       length_q, length_d;
  logic [IdxW-1:0]       index_q, index_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0]      mwd_q, mwd_d;
  logic [WIDTH-1:0]      table_q [DEPTH];
  logic [WIDTH-1:0]      table_d [DEPTH];

  logic                  wr, ctrl_wr, run_eff, last_step, step_done, busy;
  logic [PERIOD_W-1:0]   per_eff;
  logic [IdxW-1:0]       next_idx;
  logic                  unused_wdata;

  assign wr        = s_chipselect & ~s_write_n;
  assign ctrl_wr   = wr && (s_address == 3'd0);
  // A CTRL write takes effect on the FSM in the same cycle it is presented.
  assign run_eff   = ctrl_wr ? s_writedata[0] : run_q;
  assign per_eff   = (period_q == '0) ? PERIOD_W'(1) : period_q;
  // >= so that LENGTH or PERIOD lowered mid-run still terminates at the next advance.
  assign last_step = index_q >= length_q;
  assign step_done = cnt_q >= per_eff;
  assign next_idx  = last_step ? '0 : index_q + IdxW'(1);
  assign busy      = state_q != StIdle;

  assign unused_wdata = ^s_writedata[31:PERIOD_W];

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    loop_d   = loop_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    length_d = length_q;
    index_d  = index_q;
    ptr_d    = ptr_q;
    mwd_d    = mwd_q;
    table_d  = table_q;

    if (wr) begin
      case (s_address)
        3'd0: begin
          run_d    = s_writedata[0];
          loop_d   = s_writedata[1];
          irq_en_d = s_writedata[2];
          done_d   = 1'b0;
        end
        3'd1: period_d = s_writedata[PERIOD_W-1:0];
        3'd2: length_d = s_writedata[IdxW-1:0];
        3'd4: ptr_d    = s_writedata[IdxW-1:0];
        3'd5: begin
          table_d[ptr_q] = s_writedata[WIDTH-1:0];
          ptr_d          = ptr_q + IdxW'(1);
        end
        default: ;
      endcase
    end

    case (state_q)
      StIdle: begin
        if (run_eff) begin
          index_d = '0;
          mwd_d   = table_q[0];
          state_d = StWrite;
        end
      end
      StWrite: begin
        // The request is held until accepted, even if RUN was cleared meanwhile.
        if (!m_waitrequest) begin
          if (!run_eff) begin
            state_d = StIdle;
          end else begin
            cnt_d   = PERIOD_W'(1);
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (step_done && last_step && !loop_q) begin
          // Completion beats a simultaneous CTRL write: DONE ends set, written RUN kept.
          state_d = StIdle;
          done_d  = 1'b1;
          if (!ctrl_wr) run_d = 1'b0;
        end else if (!run_eff) begin
          state_d = StIdle;
        end else if (step_done) begin
          index_d = next_idx;
          mwd_d   = table_q[next_idx];
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      period_q <= DEFAULT_PERIOD;
      cnt_q    <= '0;
      length_q <= '0;
      index_q  <= '0;
      ptr_q    <= '0;
      mwd_q    <= '0;
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      loop_q   <= loop_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      length_q <= length_d;
      index_q  <= index_d;
      ptr_q    <= ptr_d;
      mwd_q    <= mwd_d;
      table_q  <= table_d;
    end
  end

  always_comb begin
    s_readdata = '0;
    case (s_address)
      3'd0: s_readdata[4:0]          = {busy, done_q, irq_en_q, loop_q, run_q};
      3'd1: s_readdata[PERIOD_W-1:0] = period_q;
      3'd2: s_readdata[IdxW-1:0]     = length_q;
      3'd3: s_readdata[IdxW-1:0]     = index_q;
      3'd4: s_readdata[IdxW-1:0]     = ptr_q;
      3'd5: s_readdata[WIDTH-1:0]    = table_q[ptr_q];
      default: ;
    endcase
  end

  assign m_address   = 3'd0;
  assign m_write_n   = state_q != StWrite;
  assign m_writedata = {{(32 - WIDTH){1'b0}}, mwd_q};
  assign irq         = done_q & irq_en_q;

endmodule
